konnect_seq: RTL and testbench
==============================

KONNECT_SEQ -- requirements
Module: konnect_seq

Interface
REQ-001 SHALL have parameter MY_ADDRESS, default 4'hF, Konnect board address matched against data_in[3:0].
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd6650, idle-edge watchdog limit in fpga_clk cycles (100 us at 66.5 MHz).
REQ-003 SHALL have port fpga_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port kreset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port k_clk_rise / k_clk_fall  in  1 each  single-cycle pulses from the k_clk edge detector.
REQ-006 SHALL have port k_clk_lvl  in  1  synchronized k_clk level.
REQ-007 SHALL have port start_rise / start_fall  in  1 each  single-cycle pulses from the start_in edge detector.
REQ-008 SHALL have port data_in  in  8  Konnect bus read-back from the bidirectional buffers.
REQ-009 SHALL have port k_in  in  32  local inputs returned to KFLOP.
REQ-010 SHALL have port err_clr  in  1  synchronous clear of frame_err.
REQ-011 SHALL have port data_out  out  8  byte driven onto the bus.
REQ-012 SHALL have port out_en_n  out  1  bus buffer tristate control; 0 = drive.
REQ-013 SHALL have port k_out  out  16  committed outputs.
REQ-014 SHALL have port k_out_valid  out  1  one-cycle pulse on commit.
REQ-015 SHALL have port frame_err  out  1  sticky error flag.
REQ-016 SHALL have port frame_cnt  out  8  count of committed frames.
REQ-017 SHALL have port xstate  out  3  debug: {state[1:0] != IDLE, beat[1:0]}.

Function
REQ-018 SHALL implement the states IDLE, ARMED, ACTIVE, SKIP.
REQ-019 SHALL, on start_rise, enter ARMED from any state, set beat to 0 and clear shadow; this abort sets frame_err only if the state was ACTIVE.
REQ-020 SHALL, on start_fall in ARMED, go ACTIVE and snapshot k_in into k_snap when data_in[3:0]==MY_ADDRESS; otherwise go SKIP.
REQ-021 SHALL, in ACTIVE, increment beat on k_clk_rise, saturating at 7.
REQ-022 SHALL, on k_clk_fall in ACTIVE, act per beat: 1 -> shadow[7:0]=data_in; 2 -> shadow[15:8]=data_in, data_out=k_snap[7:0]; 3 -> data_out=k_snap[15:8]; 4 -> data_out=k_snap[23:16]; 5 -> data_out=k_snap[31:24]; 6 -> data_out=XOR of the four k_snap bytes.
REQ-023 SHALL, on k_clk_fall with beat 7, in the same cycle set k_out=shadow, pulse k_out_valid, increment frame_cnt (255 wraps to 0), set data_out=8'h00 and go IDLE.
REQ-024 SHALL drive out_en_n=0 only when state==ACTIVE, k_clk_lvl==1 and beat>=3; otherwise out_en_n=1.
REQ-025 SHALL ignore k_clk edges in IDLE and SKIP; SKIP leaves only on start_rise or timeout.
REQ-026 SHALL, in ARMED, ACTIVE or SKIP, reload the watchdog on any edge pulse; on reaching TIMEOUT_CYC it SHALL go IDLE, discard shadow, leave k_out unchanged, and set frame_err only if ARMED or ACTIVE.
REQ-027 SHALL give start_rise priority over any k_clk edge in the same cycle; the k_clk edge is dropped.
REQ-028 SHALL give a frame_err set priority over err_clr in the same cycle.
REQ-029 SHALL leave k_out changing only at commit, never partially updated.

Reset
REQ-030 SHALL, on kreset=0, immediately reset: state=IDLE, beat=0, data_out=0, out_en_n=1, k_out=0, k_out_valid=0, frame_err=0, frame_cnt=0, shadow=0, k_snap=0, watchdog=0.
REQ-031 SHALL, on reset asserted mid-frame, abandon the frame with no commit and no error.

Structure
REQ-032 SHALL place the state encoding, beat constants (BEAT_LO=1, BEAT_HI=2, BEAT_DONE=7) and the MY_ADDRESS default in shared package konnect_pkg.
REQ-033 SHALL implement the watchdog as sub-module konnect_wdog (reload, enable, expire pulse).

Verification
REQ-034 SHALL verify the matched frame: address 4'hF, bytes 0x34/0x12, k_in=32'h77_11_AA_55 -> k_out=16'h1234, k_out_valid one cycle, bus bytes 55,AA,11,77,99, frame_cnt=1.
REQ-035 SHALL verify the address mismatch: address 4'h3 -> SKIP, out_en_n stays 1, k_out unchanged, no error.
REQ-036 SHALL verify the abort: start_rise at beat 4 -> no commit, frame_err=1, then a clean frame commits; err_clr clears the flag.
REQ-037 SHALL verify the timeout: k_clk stalls at beat 3 for TIMEOUT_CYC cycles -> IDLE, frame_err=1, k_out unchanged.
REQ-038 SHALL verify the simultaneous events: start_rise with k_clk_fall in the same cycle -> abort wins, shadow not written; frame_cnt 255 + commit -> 0.
REQ-039 SHALL verify reset mid-frame: kreset pulse at beat 5 -> all outputs at reset values, out_en_n=1 within the same cycle.

Source files
------------

// File: rtl/konnect_pkg.sv
`default_nettype none
//==============================================================================
// konnect_pkg : shared state encoding and beat constants for the Konnect sequencer (rev 1.0)
//==============================================================================
package konnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SKIP   = 2'd3
  } state_t;

  localparam logic [2:0] BEAT_LO   = 3'd1;
  localparam logic [2:0] BEAT_HI   = 3'd2;
  localparam logic [2:0] BEAT_DONE = 3'd7;

  localparam logic [3:0] MY_ADDRESS_DEF = 4'hF;

  // Check byte returned to KFLOP after the four input bytes.
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

endpackage
`default_nettype wire

// File: rtl/konnect_wdog.sv
`default_nettype none
//==============================================================================
// konnect_wdog : idle-edge watchdog, expires TIMEOUT_CYC cycles after last reload (rev 1.0)
//==============================================================================
module konnect_wdog #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd6650
) (
  input  logic fpga_clk,
  input  logic kreset,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  logic [15:0] r_cnt;

  assign expire = enable && !reload && (r_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      r_cnt <= 16'd0;
    end else if (!enable || reload || expire) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/konnect_seq.sv
`default_nettype none
//==============================================================================
// konnect_seq : Konnect bus frame sequencer - address match, shadow capture, byte return, commit (rev 1.0)
//==============================================================================
module konnect_seq
  import konnect_pkg::*;
#(
  parameter logic [3:0]  MY_ADDRESS  = MY_ADDRESS_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd6650
) (
  input  logic        fpga_clk,
  input  logic        kreset,
  input  logic        k_clk_rise,
  input  logic        k_clk_fall,
  input  logic        k_clk_lvl,
  input  logic        start_rise,
  input  logic        start_fall,
  input  logic [7:0]  data_in,
  input  logic [31:0] k_in,
  input  logic        err_clr,
  output logic [7:0]  data_out,
  output logic        out_en_n,
  output logic [15:0] k_out,
  output logic        k_out_valid,
  output logic        frame_err,
  output logic [7:0]  frame_cnt,
  output logic [2:0]  xstate
);

  state_t      r_state;
  logic [2:0]  r_beat;
  logic [15:0] r_shadow;
  logic [31:0] r_k_snap;

  logic w_any_edge;
  logic w_wd_en;
  logic w_expire;
  logic w_set_err;

  assign w_any_edge = k_clk_rise | k_clk_fall | start_rise | start_fall;
  assign w_wd_en    = (r_state != ST_IDLE);

  // Abort and expiry are mutually exclusive: any start edge also reloads the watchdog.
  assign w_set_err = start_rise ? (r_state == ST_ACTIVE)
                                : (w_expire && (r_state == ST_ARMED || r_state == ST_ACTIVE));

  assign out_en_n = !((r_state == ST_ACTIVE) && k_clk_lvl && (r_beat >= 3'd3));
  assign xstate   = {(r_state != ST_IDLE), r_beat[1:0]};

  konnect_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .fpga_clk(fpga_clk),
    .kreset  (kreset),
    .enable  (w_wd_en),
    .reload  (w_any_edge),
    .expire  (w_expire)
  );

  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      r_state     <= ST_IDLE;
      r_beat      <= 3'd0;
      r_shadow    <= 16'd0;
      r_k_snap    <= 32'd0;
      data_out    <= 8'd0;
      k_out       <= 16'd0;
      k_out_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      k_out_valid <= 1'b0;

      if (w_set_err) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end

      if (start_rise) begin
        r_state  <= ST_ARMED;
        r_beat   <= 3'd0;
        r_shadow <= 16'd0;
      end else if (w_expire) begin
        r_state  <= ST_IDLE;
        r_beat   <= 3'd0;
        r_shadow <= 16'd0;
      end else begin
        case (r_state)
          ST_ARMED: begin
            if (start_fall) begin
              if (data_in[3:0] == MY_ADDRESS) begin
                r_state  <= ST_ACTIVE;
                r_k_snap <= k_in;
              end else begin
                r_state <= ST_SKIP;
              end
            end
          end
          ST_ACTIVE: begin
            if (k_clk_rise && (r_beat != BEAT_DONE)) begin
              r_beat <= r_beat + 3'd1;
            end
            // Fall-edge actions use the beat reached by the preceding rise.
            if (k_clk_fall) begin
              case (r_beat)
                BEAT_LO: r_shadow[7:0] <= data_in;
                BEAT_HI: begin
                  r_shadow[15:8] <= data_in;
                  data_out       <= r_k_snap[7:0];
                end
                3'd3: data_out <= r_k_snap[15:8];
                3'd4: data_out <= r_k_snap[23:16];
                3'd5: data_out <= r_k_snap[31:24];
                3'd6: data_out <= xor_bytes(r_k_snap);
                BEAT_DONE: begin
                  k_out       <= r_shadow;
                  k_out_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 8'd1;
                  data_out    <= 8'h00;
                  r_state     <= ST_IDLE;
                  r_beat      <= 3'd0;
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_konnect_seq.sv
`default_nettype none
//==============================================================================
// tb_konnect_seq : table-driven frames plus hand sequences, bus bytes checked via scoreboard (rev 1.0)
//==============================================================================
module tb_konnect_seq;

  localparam logic [15:0] T = 16'd6650;

  logic        fpga_clk = 1'b0;
  logic        kreset = 1'b0;
  logic        k_clk_rise = 1'b0, k_clk_fall = 1'b0, k_clk_lvl = 1'b0;
  logic        start_rise = 1'b0, start_fall = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [31:0] k_in = 32'h0;
  logic        err_clr = 1'b0;
  logic [7:0]  data_out;
  logic        out_en_n;
  logic [15:0] k_out;
  logic        k_out_valid;
  logic        frame_err;
  logic [7:0]  frame_cnt;
  logic [2:0]  xstate;

  always #5 fpga_clk = ~fpga_clk;

  konnect_seq #(
    .MY_ADDRESS (4'hF),
    .TIMEOUT_CYC(T)
  ) dut (
    .fpga_clk   (fpga_clk),
    .kreset     (kreset),
    .k_clk_rise (k_clk_rise),
    .k_clk_fall (k_clk_fall),
    .k_clk_lvl  (k_clk_lvl),
    .start_rise (start_rise),
    .start_fall (start_fall),
    .data_in    (data_in),
    .k_in       (k_in),
    .err_clr    (err_clr),
    .data_out   (data_out),
    .out_en_n   (out_en_n),
    .k_out      (k_out),
    .k_out_valid(k_out_valid),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt),
    .xstate     (xstate)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [31:0] kin;
    logic        match;
    logic [15:0] kout;
    logic [7:0]  cnt;
  } vec_t;

  vec_t        vecs[5];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  sb[$];
  logic [15:0] exp_kout;
  logic [7:0]  exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One fpga_clk cycle with the given pulses; outputs are sampled 1 unit after the edge.
  task automatic step(input logic kr, input logic kf, input logic sr, input logic sf, input logic [7:0] din);
    k_clk_rise = kr; k_clk_fall = kf; start_rise = sr; start_fall = sf; data_in = din;
    if (kr) k_clk_lvl = 1'b1;
    if (kf) k_clk_lvl = 1'b0;
    @(posedge fpga_clk); #1;
    k_clk_rise = 1'b0; k_clk_fall = 1'b0; start_rise = 1'b0; start_fall = 1'b0; err_clr = 1'b0;
  endtask

  function automatic logic [7:0] bus_byte(input int b, input logic [31:0] kin);
    case (b)
      2: return kin[7:0];
      3: return kin[15:8];
      4: return kin[23:16];
      5: return kin[31:24];
      default: return kin[7:0] ^ kin[15:8] ^ kin[23:16] ^ kin[31:24];
    endcase
  endfunction

  task automatic start_frame(input logic [3:0] addr, input logic [31:0] kin);
    k_in = kin;
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, {4'h0, addr});
  endtask

  task automatic run_beats(input int first, input int last, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [31:0] kin, input logic active);
    for (int b = first; b <= last; b++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      if (active && b >= 3) begin
        check($sformatf("out_en_drive_b%0d", b), out_en_n, 0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: beat %0d bus shows %0h, no byte expected", b, data_out);
        end else begin
          check($sformatf("bus_b%0d", b), data_out, sb.pop_front());
        end
      end else begin
        check($sformatf("out_en_off_b%0d", b), out_en_n, 1);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, (b == 1) ? lo : ((b == 2) ? hi : 8'h00));
      check($sformatf("out_en_low_b%0d", b), out_en_n, 1);
      if (active && b >= 2 && b <= 6) sb.push_back(bus_byte(b, kin));
    end
  endtask

  task automatic do_frame(input logic [7:0] lo, input logic [7:0] hi, input logic [31:0] kin);
    start_frame(4'hF, kin);
    run_beats(1, 7, lo, hi, kin, 1'b1);
    exp_cnt++;
    exp_kout = {hi, lo};
    check("commit_valid", k_out_valid, 1);
    check("commit_kout", k_out, exp_kout);
    check("commit_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_out_en_n"}, out_en_n, 1);
    check({tag, "_k_out"}, k_out, 0);
    check({tag, "_valid"}, k_out_valid, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_cnt"}, frame_cnt, 0);
    check({tag, "_xstate"}, xstate, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'hF, 8'h34, 8'h12, 32'h7711AA55, 1'b1, 16'h1234, 8'd1};
    vecs[1] = '{4'h3, 8'hAB, 8'hCD, 32'h01020304, 1'b0, 16'h1234, 8'd1};
    vecs[2] = '{4'hF, 8'hEF, 8'hBE, 32'hDEADBEEF, 1'b1, 16'hBEEF, 8'd2};
    vecs[3] = '{4'h0, 8'h11, 8'h22, 32'hCAFEF00D, 1'b0, 16'hBEEF, 8'd2};
    vecs[4] = '{4'hF, 8'h00, 8'h00, 32'hFFFFFFFF, 1'b1, 16'h0000, 8'd3};

    // Reset state, held and after release.
    repeat (3) @(posedge fpga_clk);
    #1;
    check_reset_values("rst_held");
    kreset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_reset_values("rst_rel");

    // Table: matched and mismatched frames.
    for (int i = 0; i < 5; i++) begin
      start_frame(vecs[i].addr, vecs[i].kin);
      check($sformatf("v%0d_armed_out", i), xstate, 3'b100);
      run_beats(1, 7, vecs[i].lo, vecs[i].hi, vecs[i].kin, vecs[i].match);
      check($sformatf("v%0d_valid", i), k_out_valid, vecs[i].match);
      check($sformatf("v%0d_kout", i), k_out, vecs[i].kout);
      check($sformatf("v%0d_cnt", i), frame_cnt, vecs[i].cnt);
      check($sformatf("v%0d_err", i), frame_err, 0);
      check($sformatf("v%0d_xstate", i), xstate, vecs[i].match ? 3'b000 : 3'b100);
      check($sformatf("v%0d_sb_empty", i), sb.size(), 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check($sformatf("v%0d_valid_pulse", i), k_out_valid, 0);
    end
    exp_kout = 16'h0000;
    exp_cnt  = 8'd3;

    // Abort at beat 4, then a clean frame, then err_clr.
    start_frame(4'hF, 32'h0BADF00D);
    run_beats(1, 4, 8'h21, 8'h43, 32'h0BADF00D, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    sb.delete();
    check("abort_err", frame_err, 1);
    check("abort_valid", k_out_valid, 0);
    check("abort_kout", k_out, exp_kout);
    check("abort_xstate", xstate, 3'b100);
    k_in = 32'h89ABCDEF;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F);
    run_beats(1, 7, 8'h78, 8'h56, 32'h89ABCDEF, 1'b1);
    exp_cnt++;
    exp_kout = 16'h5678;
    check("reframe_valid", k_out_valid, 1);
    check("reframe_kout", k_out, exp_kout);
    check("reframe_cnt", frame_cnt, exp_cnt);
    check("err_sticky", frame_err, 1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("err_clr", frame_err, 0);

    // Watchdog: k_clk stalls after beat 3.
    start_frame(4'hF, 32'h00000001);
    run_beats(1, 3, 8'h99, 8'h88, 32'h00000001, 1'b1);
    sb.delete();
    repeat (int'(T) - 1) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("wd_not_yet", xstate[2], 1);
    check("wd_no_err_yet", frame_err, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("wd_idle", xstate, 0);
    check("wd_err", frame_err, 1);
    check("wd_kout", k_out, exp_kout);
    check("wd_valid", k_out_valid, 0);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // start_rise together with k_clk_fall: the dropped fall must not land EE in shadow.
    start_frame(4'hF, 32'h13572468);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
    check("sim_xstate", xstate, 3'b100);
    check("sim_err", frame_err, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_beats(2, 7, 8'h00, 8'h9A, 32'h13572468, 1'b1);
    exp_cnt++;
    exp_kout = 16'h9A00;
    check("sim_kout", k_out, exp_kout);
    check("sim_cnt", frame_cnt, exp_cnt);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // frame_cnt wrap 255 -> 0.
    while (exp_cnt != 8'hFF) do_frame(8'hA5, 8'h5A, $urandom);
    do_frame(8'h3C, 8'hC3, 32'h24681357);
    check("wrap_cnt", frame_cnt, 0);

    // Reset asserted mid-frame while the bus is driven.
    start_frame(4'hF, 32'hFEDCBA98);
    run_beats(1, 4, 8'h01, 8'h02, 32'hFEDCBA98, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("pre_rst_drive", out_en_n, 0);
    check("pre_rst_bus", data_out, sb.pop_front());
    sb.delete();
    #1 kreset = 1'b0;
    #1;
    check_reset_values("mid_rst");
    #1 kreset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    check("post_rst_valid", k_out_valid, 0);
    check("post_rst_kout", k_out, 0);
    check("post_rst_xstate", xstate, 0);
    exp_cnt = 8'd0;
    do_frame(8'h66, 8'h77, 32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
